// File: rtl/mdu_pkg.sv
// mdu_pkg: shared constants for the multiply/divide unit.
// Contents:
//   MDU_* op codes       - operation select driven by the decoder
//   ST_*                 - FSM state encoding (IDLE/MUL/DIV/FIX)
//   MDU_DIV0_LO          - LO value produced by a divide by zero
//   mdu_is_div/signed    - op-code classification helpers
package mdu_pkg;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_FIX  = 2'd3;

    // Divide by zero is not trapped: LO saturates to all ones, HI keeps the dividend.
    localparam logic [31:0] MDU_DIV0_LO = 32'hFFFF_FFFF;

    function automatic logic mdu_is_div(input logic [2:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic mdu_is_signed(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

endpackage

// File: rtl/mdu_div_core.sv
// mdu_div_core: unsigned restoring radix-2 divider, one quotient bit per step.
// Ports:
//   clk_i, rst_ni   - clock, asynchronous active-low reset
//   load_i          - capture dividend/divisor and clear the partial remainder
//   step_i          - perform one iteration (W steps give the final result)
//   dividend_i      - unsigned dividend
//   divisor_i       - unsigned divisor (must be non-zero; zero is handled by the caller)
//   quotient_o      - quotient, valid after W steps
//   remainder_o     - remainder, valid after W steps
module mdu_div_core #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic         step_i,
    input  logic [W-1:0] dividend_i,
    input  logic [W-1:0] divisor_i,
    output logic [W-1:0] quotient_o,
    output logic [W-1:0] remainder_o
);

    logic [W-1:0] rem_q, rem_d;
    logic [W-1:0] quo_q, quo_d;
    logic [W-1:0] dvs_q, dvs_d;
    logic [W:0]   trial;
    logic [W:0]   diff;

    // The quotient register starts out holding the dividend; each step shifts
    // its top bit into the partial remainder and shifts the new quotient bit in
    // from the bottom. A borrow out of the trial subtraction (diff[W]) means
    // the divisor did not fit, so the remainder is restored.
    always_comb begin
        rem_d = rem_q;
        quo_d = quo_q;
        dvs_d = dvs_q;
        trial = {rem_q, quo_q[W-1]};
        diff  = trial - {1'b0, dvs_q};
        if (load_i) begin
            rem_d = '0;
            quo_d = dividend_i;
            dvs_d = divisor_i;
        end else if (step_i) begin
            if (!diff[W]) begin
                rem_d = diff[W-1:0];
                quo_d = {quo_q[W-2:0], 1'b1};
            end else begin
                rem_d = trial[W-1:0];
                quo_d = {quo_q[W-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
        end
    end

    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

endmodule

// File: rtl/mdu_hilo.sv
// mdu_hilo: MIPS multiply/divide unit with architectural HI/LO registers.
// Runs MULT/MULTU/DIV/DIVU/MTHI/MTLO on the register-file operands from EX.
// Ports:
//   clk_i, rst_ni   - clock, asynchronous active-low reset
//   en_i            - global pipeline enable; all state holds while low
//   start_i         - request a new operation (accepted only when idle and enabled)
//   op_i            - operation code (mdu_pkg MDU_*)
//   src_a_i         - rs operand: dividend / multiplicand / MTHI-MTLO source
//   src_b_i         - rt operand: divisor / multiplier
//   busy_o          - multi-cycle operation in progress
//   done_o          - one-cycle pulse when HI/LO first show a new result
//   hi_o, lo_o      - HI and LO registers
// Build option: MDU_FAST_MUL_EN selects a single-cycle multiplier instead of
// the iterative shift-add multiplier. Division is the same in both builds.
module mdu_hilo
    import mdu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int DIV_CYCLES = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            en_i,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] src_a_i,
    input  logic [XLEN-1:0] src_b_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    localparam int CW = $clog2(XLEN);

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic              done_q, done_d;
    logic [XLEN-1:0]   src_a_q, src_a_d;
    logic              is_div_q, is_div_d;
    logic              div_zero_q, div_zero_d;
    logic              res_neg_q, res_neg_d;
    logic              rem_neg_q, rem_neg_d;
    logic [2*XLEN-1:0] prod_q, prod_d;
`ifndef MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0]   mplier_q, mplier_d;
`endif

    logic            accept;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] mag_a, mag_b;
    logic [XLEN-1:0] quotient, remainder;

    assign accept = en_i && start_i && (state_q == ST_IDLE);

    // Signed ops work on magnitudes; the signs are remembered so FIX can
    // negate the result afterwards.
    assign a_neg = mdu_is_signed(op_i) && src_a_i[XLEN-1];
    assign b_neg = mdu_is_signed(op_i) && src_b_i[XLEN-1];
    assign mag_a = a_neg ? -src_a_i : src_a_i;
    assign mag_b = b_neg ? -src_b_i : src_b_i;

    mdu_div_core #(.W(XLEN)) u_div_core (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .load_i      (accept && mdu_is_div(op_i)),
        .step_i      (en_i && (state_q == ST_DIV)),
        .dividend_i  (mag_a),
        .divisor_i   (mag_b),
        .quotient_o  (quotient),
        .remainder_o (remainder)
    );

    // Next-state logic. HI/LO change only on MTHI/MTLO accept or on the
    // FIX->IDLE edge, so MFHI during busy reads the previous values.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        src_a_d    = src_a_q;
        is_div_d   = is_div_q;
        div_zero_d = div_zero_q;
        res_neg_d  = res_neg_q;
        rem_neg_d  = rem_neg_q;
        prod_d     = prod_q;
`ifndef MDU_FAST_MUL_EN
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cnt_d = '0;
                    case (op_i)
                        MDU_MTHI: hi_d = src_a_i;
                        MDU_MTLO: lo_d = src_a_i;
                        MDU_DIV, MDU_DIVU: begin
                            src_a_d    = src_a_i;
                            is_div_d   = 1'b1;
                            div_zero_d = (src_b_i == '0);
                            res_neg_d  = a_neg ^ b_neg;
                            rem_neg_d  = a_neg;
                            state_d    = ST_DIV;
                        end
                        MDU_MULT, MDU_MULTU: begin
                            is_div_d  = 1'b0;
                            res_neg_d = a_neg ^ b_neg;
`ifdef MDU_FAST_MUL_EN
                            prod_d  = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
                            state_d = ST_FIX;
`else
                            prod_d   = '0;
                            mcand_d  = {{XLEN{1'b0}}, mag_a};
                            mplier_d = mag_b;
                            state_d  = ST_MUL;
`endif
                        end
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
`ifndef MDU_FAST_MUL_EN
                if (mplier_q[0]) begin
                    prod_d = prod_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
`endif
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(XLEN - 1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_DIV: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(DIV_CYCLES - 1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                if (is_div_q) begin
                    if (div_zero_q) begin
                        lo_d = XLEN'(MDU_DIV0_LO);
                        hi_d = src_a_q;
                    end else begin
                        lo_d = res_neg_q ? -quotient : quotient;
                        hi_d = rem_neg_q ? -remainder : remainder;
                    end
                end else begin
                    {hi_d, lo_d} = res_neg_q ? -prod_q : prod_q;
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // All state, including the done pulse, is frozen while en_i is low.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            src_a_q    <= '0;
            is_div_q   <= 1'b0;
            div_zero_q <= 1'b0;
            res_neg_q  <= 1'b0;
            rem_neg_q  <= 1'b0;
            prod_q     <= '0;
`ifndef MDU_FAST_MUL_EN
            mcand_q    <= '0;
            mplier_q   <= '0;
`endif
        end else if (en_i) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            src_a_q    <= src_a_d;
            is_div_q   <= is_div_d;
            div_zero_q <= div_zero_d;
            res_neg_q  <= res_neg_d;
            rem_neg_q  <= rem_neg_d;
            prod_q     <= prod_d;
`ifndef MDU_FAST_MUL_EN
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
`endif
        end
    end

    assign busy_o = (state_q != ST_IDLE);
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: self-checking bench for mdu_hilo against an arithmetic
// reference model of HI/LO. Honors MDU_FAST_MUL_EN for multiply latency.
module tb_mdu_hilo;
    import mdu_pkg::*;

    logic        clk;
    logic        rstN;
    logic        en;
    logic        start;
    logic [2:0]  op;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    logic [31:0] modelHi = 32'h0;
    logic [31:0] modelLo = 32'h0;

    mdu_hilo #(.XLEN(32), .DIV_CYCLES(32)) dut (
        .clk_i   (clk),
        .rst_ni  (rstN),
        .en_i    (en),
        .start_i (start),
        .op_i    (op),
        .src_a_i (srcA),
        .src_b_i (srcB),
        .busy_o  (busy),
        .done_o  (done),
        .hi_o    (hi),
        .lo_o    (lo)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Last-resort guard so a wedged run still terminates.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Architectural effect of one accepted operation on HI/LO, from plain
    // integer arithmetic.
    function automatic void refModel(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        longint sp;
        longint unsigned up;
        sa = a;
        sb = b;
        case (o)
            MDU_MULT: begin
                sp = longint'(sa) * longint'(sb);
                {modelHi, modelLo} = sp;
            end
            MDU_MULTU: begin
                up = 64'(a) * 64'(b);
                {modelHi, modelLo} = up;
            end
            MDU_DIV: begin
                if (b == 32'h0) begin
                    modelLo = 32'hFFFF_FFFF;
                    modelHi = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    modelLo = 32'h8000_0000;
                    modelHi = 32'h0;
                end else begin
                    modelLo = sa / sb;
                    modelHi = sa % sb;
                end
            end
            MDU_DIVU: begin
                if (b == 32'h0) begin
                    modelLo = 32'hFFFF_FFFF;
                    modelHi = a;
                end else begin
                    modelLo = a / b;
                    modelHi = a % b;
                end
            end
            MDU_MTHI: modelHi = a;
            MDU_MTLO: modelLo = a;
            default: ;
        endcase
    endfunction

    // Cycles busy stays high for each operation with en held high.
    function automatic int expBusy(input logic [2:0] o);
        if (o == MDU_DIV || o == MDU_DIVU) return 33;
`ifdef MDU_FAST_MUL_EN
        if (o == MDU_MULT || o == MDU_MULTU) return 1;
`else
        if (o == MDU_MULT || o == MDU_MULTU) return 33;
`endif
        return 0;
    endfunction

    // Issues one operation, scrambles the operand inputs after acceptance,
    // and measures busy length and the done pulse position.
    task automatic runOp(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int busyCycles, output logic doneAtEnd, output logic doneAfter,
                         output logic timedOut);
        @(negedge clk);
        op = o;
        srcA = a;
        srcB = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        srcA = $urandom;
        srcB = $urandom;
        busyCycles = 0;
        while (busy && busyCycles <= 200) begin
            busyCycles++;
            @(posedge clk);
            #1;
        end
        timedOut = busy;
        doneAtEnd = done;
        @(posedge clk);
        #1;
        doneAfter = done;
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        en = 1'b1;
        start = 1'b0;
        op = MDU_MULT;
        srcA = 32'h0;
        srcB = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (hi !== 32'h0) begin errors++; $display("[TB] FAIL reset_hi: got %h required %h", hi, 32'h0); end
        checks++;
        if (lo !== 32'h0) begin errors++; $display("[TB] FAIL reset_lo: got %h required %h", lo, 32'h0); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b required 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b required 0", done); end
        @(negedge clk);
        rstN = 1'b1;
        modelHi = 32'h0;
        modelLo = 32'h0;
    endtask

    task automatic test_moves();
        logic [2:0] mOp[5] = '{MDU_MTHI, MDU_MTLO, 3'd6, 3'd7, MDU_MTHI};
        logic [31:0] mA[5] = '{32'h1234_5678, 32'hCAFE_0000, 32'hDEAD_BEEF, 32'h0BAD_F00D, 32'h0};
        int bc;
        logic dEnd, dAfter, tOut;
        mA[4] = $urandom;
        for (int i = 0; i < 5; i++) begin
            refModel(mOp[i], mA[i], 32'h0);
            runOp(mOp[i], mA[i], $urandom, bc, dEnd, dAfter, tOut);
            checks++;
            if (bc !== 0) begin errors++; $display("[TB] FAIL move_busy[%0d]: got %0d busy cycles required 0", i, bc); end
            checks++;
            if (dEnd !== 1'b0 || dAfter !== 1'b0) begin errors++; $display("[TB] FAIL move_done[%0d]: got %b%b required 00", i, dEnd, dAfter); end
            checks++;
            if (hi !== modelHi || lo !== modelLo) begin
                errors++;
                $display("[TB] FAIL move_hilo[%0d]: got %h_%h required %h_%h", i, hi, lo, modelHi, modelLo);
            end
        end
    endtask

    task automatic test_div();
        logic [2:0] dOp[5] = '{MDU_DIV, MDU_DIVU, MDU_DIV, MDU_DIV, MDU_DIVU};
        logic [31:0] dA[5] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h55, 32'h8000_0000, 32'h1234_5678};
        logic [31:0] dB[5] = '{32'h2, 32'h2, 32'h0, 32'hFFFF_FFFF, 32'h0};
        logic [2:0] o;
        logic [31:0] a, b;
        int bc;
        logic dEnd, dAfter, tOut;
        for (int i = 0; i < 25; i++) begin
            if (i < 5) begin
                o = dOp[i]; a = dA[i]; b = dB[i];
            end else begin
                o = ($urandom_range(0, 1) == 0) ? MDU_DIV : MDU_DIVU;
                a = $urandom;
                case ($urandom_range(0, 3))
                    0: b = $urandom_range(1, 15);
                    1: b = 32'h0 - $urandom_range(1, 15);
                    2: b = $urandom_range(0, 1) == 0 ? 32'h0 : $urandom_range(1, 65535);
                    default: b = $urandom;
                endcase
            end
            refModel(o, a, b);
            runOp(o, a, b, bc, dEnd, dAfter, tOut);
            checks++;
            if (tOut || bc !== expBusy(o)) begin errors++; $display("[TB] FAIL div_busy[%0d]: got %0d cycles required %0d", i, bc, expBusy(o)); end
            checks++;
            if (dEnd !== 1'b1 || dAfter !== 1'b0) begin errors++; $display("[TB] FAIL div_done[%0d]: got %b%b required 10", i, dEnd, dAfter); end
            checks++;
            if (lo !== modelLo) begin errors++; $display("[TB] FAIL div_lo[%0d] op%0d %h/%h: got %h required %h", i, o, a, b, lo, modelLo); end
            checks++;
            if (hi !== modelHi) begin errors++; $display("[TB] FAIL div_hi[%0d] op%0d %h/%h: got %h required %h", i, o, a, b, hi, modelHi); end
        end
    endtask

    task automatic test_mul();
        logic [2:0] mOp[4] = '{MDU_MULT, MDU_MULTU, MDU_MULT, MDU_MULT};
        logic [31:0] mA[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        logic [31:0] mB[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000};
        logic [2:0] o;
        logic [31:0] a, b;
        int bc;
        logic dEnd, dAfter, tOut;
        for (int i = 0; i < 20; i++) begin
            if (i < 4) begin
                o = mOp[i]; a = mA[i]; b = mB[i];
            end else begin
                o = ($urandom_range(0, 1) == 0) ? MDU_MULT : MDU_MULTU;
                a = $urandom;
                b = $urandom;
            end
            refModel(o, a, b);
            runOp(o, a, b, bc, dEnd, dAfter, tOut);
            checks++;
            if (tOut || bc !== expBusy(o)) begin errors++; $display("[TB] FAIL mul_busy[%0d]: got %0d cycles required %0d", i, bc, expBusy(o)); end
            checks++;
            if (dEnd !== 1'b1 || dAfter !== 1'b0) begin errors++; $display("[TB] FAIL mul_done[%0d]: got %b%b required 10", i, dEnd, dAfter); end
            checks++;
            if (hi !== modelHi || lo !== modelLo) begin
                errors++;
                $display("[TB] FAIL mul_hilo[%0d] op%0d %h*%h: got %h_%h required %h_%h", i, o, a, b, hi, lo, modelHi, modelLo);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] o;
        logic [31:0] a, b;
        int bc;
        logic dEnd, dAfter, tOut;
        for (int i = 0; i < 20; i++) begin
            o = 3'($urandom_range(0, 7));
            a = $urandom;
            b = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
            refModel(o, a, b);
            runOp(o, a, b, bc, dEnd, dAfter, tOut);
            checks++;
            if (tOut || bc !== expBusy(o)) begin errors++; $display("[TB] FAIL b2b_busy[%0d] op%0d: got %0d required %0d", i, o, bc, expBusy(o)); end
            checks++;
            if (hi !== modelHi || lo !== modelLo) begin
                errors++;
                $display("[TB] FAIL b2b_hilo[%0d] op%0d: got %h_%h required %h_%h", i, o, hi, lo, modelHi, modelLo);
            end
        end
    endtask

    task automatic test_en_stall();
        int bc;
        @(negedge clk);
        op = MDU_DIVU;
        srcA = 32'd100;
        srcB = 32'd7;
        start = 1'b1;
        en = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        srcA = $urandom;
        bc = 0;
        for (int k = 0; k < 200 && busy; k++) begin
            bc++;
            @(negedge clk);
            en = !(k >= 10 && k < 15);
            if (k == 3) begin
                start = 1'b1;
                op = MDU_MTHI;
                srcA = 32'hDEAD_BEEF;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        en = 1'b1;
        start = 1'b0;
        refModel(MDU_DIVU, 32'd100, 32'd7);
        checks++;
        if (bc !== 38) begin errors++; $display("[TB] FAIL stall_busy: got %0d cycles required 38", bc); end
        checks++;
        if (done !== 1'b1) begin errors++; $display("[TB] FAIL stall_done: got %b required 1", done); end
        checks++;
        if (lo !== 32'd14) begin errors++; $display("[TB] FAIL stall_lo: got %h required %h", lo, 32'd14); end
        checks++;
        if (hi !== 32'd2) begin errors++; $display("[TB] FAIL stall_hi: got %h required %h", hi, 32'd2); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        int bc;
        int doneSeen;
        logic dEnd, dAfter, tOut;
        runOp(MDU_MTHI, 32'hA5A5_0001, 32'h0, bc, dEnd, dAfter, tOut);
        runOp(MDU_MTLO, 32'h5A5A_0002, 32'h0, bc, dEnd, dAfter, tOut);
        @(negedge clk);
        op = MDU_DIVU;
        srcA = $urandom;
        srcB = $urandom_range(1, 1000);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rstN = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy: got %b required 0", busy); end
        checks++;
        if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("[TB] FAIL midrst_hilo: got %h_%h required 0_0", hi, lo); end
        modelHi = 32'h0;
        modelLo = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;
        doneSeen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) doneSeen++;
        end
        checks++;
        if (doneSeen !== 0) begin errors++; $display("[TB] FAIL midrst_nodone: got %0d active cycles required 0", doneSeen); end
    endtask

    initial begin
        test_reset();
        test_moves();
        test_div();
        test_mul();
        test_back_to_back();
        test_en_stall();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
